// File: rtl/mdu_issue_ctrl_pkg.sv
// Shared MDU definitions: E-stage op codes, MDUCtrl codes and default latencies.
// Controller and MDU both import this so the latencies have a single source.
package mdu_issue_ctrl_pkg;

  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;

  typedef enum logic [3:0] {
    MD_OP_NONE  = 4'd0,
    MD_OP_MULT  = 4'd1,
    MD_OP_MULTU = 4'd2,
    MD_OP_DIV   = 4'd3,
    MD_OP_DIVU  = 4'd4,
    MD_OP_MTHI  = 4'd5,
    MD_OP_MTLO  = 4'd6,
    MD_OP_MFHI  = 4'd7,
    MD_OP_MFLO  = 4'd8
  } md_op_e;

  localparam logic [2:0] MDU_MULT  = 3'd1;
  localparam logic [2:0] MDU_MULTU = 3'd2;
  localparam logic [2:0] MDU_DIV   = 3'd3;
  localparam logic [2:0] MDU_DIVU  = 3'd4;
  localparam logic [2:0] MDU_MTHI  = 3'd5;
  localparam logic [2:0] MDU_MTLO  = 3'd6;

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} trk_state_e;

  // Only ops that actually start the MDU get a non-zero control code.
  function automatic logic [2:0] mdu_ctrl_of(input logic [3:0] op);
    case (op)
      MD_OP_MULT:  return MDU_MULT;
      MD_OP_MULTU: return MDU_MULTU;
      MD_OP_DIV:   return MDU_DIV;
      MD_OP_DIVU:  return MDU_DIVU;
      MD_OP_MTHI:  return MDU_MTHI;
      MD_OP_MTLO:  return MDU_MTLO;
      default:     return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/mdu_issue_ctrl_if.sv
// E-stage <-> MDU issue bundle; master drives the E-stage side and MDU Busy.
interface mdu_issue_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             e_valid;
  logic [3:0]       e_mdu_op;
  logic [31:0]      e_rs;
  logic [31:0]      e_rt;
  logic             flush;
  logic             mdu_busy;
  logic             mdu_start;
  logic [2:0]       mdu_ctrl;
  logic [31:0]      mdu_src_a;
  logic [31:0]      mdu_src_b;
  logic             stall_e;
  logic             mdu_done;
  logic             err_sync;
  logic [CNT_W-1:0] busy_cycles;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output e_valid, e_mdu_op, e_rs, e_rt, flush, mdu_busy,
    input  mdu_start, mdu_ctrl, mdu_src_a, mdu_src_b, stall_e,
           mdu_done, err_sync, busy_cycles, stall_cycles
  );

  modport slave (
    input  e_valid, e_mdu_op, e_rs, e_rt, flush, mdu_busy,
    output mdu_start, mdu_ctrl, mdu_src_a, mdu_src_b, stall_e,
           mdu_done, err_sync, busy_cycles, stall_cycles
  );
endinterface

// File: rtl/mdu_issue_ctrl_busy_tracker.sv
// Shadow of MDU occupancy: IDLE/BUSY countdown, completion pulse and a sticky
// flag raised whenever the shadow disagrees with the MDU's own Busy.
module mdu_busy_tracker
  import mdu_issue_ctrl_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_issue_md,
  input  logic i_is_div,
  input  logic i_mdu_busy,
  output logic o_busy,
  output logic o_done,
  output logic o_err_sync
);
  localparam int MAX_LAT  = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
  localparam int CNT_BITS = $clog2(MAX_LAT + 1);

  trk_state_e          r_state, w_state_nxt;
  logic [CNT_BITS-1:0] r_cnt, w_cnt_nxt;
  logic                r_done, w_done_nxt;
  logic                r_err, w_err_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    w_err_nxt   = r_err | ((r_state == ST_BUSY) ^ i_mdu_busy);
    case (r_state)
      ST_IDLE: begin
        if (i_issue_md) begin
          w_state_nxt = ST_BUSY;
          w_cnt_nxt   = i_is_div ? CNT_BITS'(DIV_LAT) : CNT_BITS'(MULT_LAT);
        end
      end
      ST_BUSY: begin
        w_cnt_nxt = r_cnt - CNT_BITS'(1);
        // Last busy cycle: the pulse lands in the first IDLE cycle.
        if (r_cnt == CNT_BITS'(1)) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_busy     = (r_state == ST_BUSY);
  assign o_done     = r_done;
  assign o_err_sync = r_err;
endmodule

// File: rtl/mdu_issue_ctrl.sv
// E-stage issue controller for the multi-cycle MDU: decode, start/stall
// generation, occupancy tracking and performance counters.
module mdu_issue_ctrl
  import mdu_issue_ctrl_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int CNT_W    = 32
) (
  input logic             clk,
  input logic             reset,
  mdu_issue_ctrl_if.slave bus
);
  logic             w_is_md, w_is_mt, w_is_mf, w_is_div;
  logic             w_any_md, w_busy, w_issue, w_stall;
  logic [CNT_W-1:0] r_busy_cycles, r_stall_cycles;

  always_comb begin
    w_is_md  = 1'b0;
    w_is_mt  = 1'b0;
    w_is_mf  = 1'b0;
    w_is_div = 1'b0;
    case (bus.e_mdu_op)
      MD_OP_MULT, MD_OP_MULTU: w_is_md = 1'b1;
      MD_OP_DIV, MD_OP_DIVU: begin
        w_is_md  = 1'b1;
        w_is_div = 1'b1;
      end
      MD_OP_MTHI, MD_OP_MTLO: w_is_mt = 1'b1;
      MD_OP_MFHI, MD_OP_MFLO: w_is_mf = 1'b1;
      default: ;
    endcase
  end

  assign w_any_md = w_is_md | w_is_mt | w_is_mf;
  // Flush wins: a killed instruction neither starts nor holds the pipe.
  assign w_stall  = bus.e_valid & w_any_md & w_busy & ~bus.flush;
  assign w_issue  = bus.e_valid & (w_is_md | w_is_mt) & ~w_busy & ~bus.flush;

  mdu_busy_tracker #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) u_tracker (
    .clk        (clk),
    .rst_n      (reset),
    .i_issue_md (w_issue & w_is_md),
    .i_is_div   (w_is_div),
    .i_mdu_busy (bus.mdu_busy),
    .o_busy     (w_busy),
    .o_done     (bus.mdu_done),
    .o_err_sync (bus.err_sync)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy_cycles  <= '0;
      r_stall_cycles <= '0;
    end else begin
      if (w_busy)  r_busy_cycles  <= r_busy_cycles + CNT_W'(1);
      if (w_stall) r_stall_cycles <= r_stall_cycles + CNT_W'(1);
    end
  end

  assign bus.mdu_start    = w_issue;
  assign bus.mdu_ctrl     = mdu_ctrl_of(bus.e_mdu_op);
  assign bus.mdu_src_a    = bus.e_rs;
  assign bus.mdu_src_b    = bus.e_rt;
  assign bus.stall_e      = w_stall;
  assign bus.busy_cycles  = r_busy_cycles;
  assign bus.stall_cycles = r_stall_cycles;
endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Directed bench for mdu_issue_ctrl with a small behavioural MDU Busy model.
module tb_mdu_issue_ctrl;
  import mdu_issue_ctrl_pkg::*;

  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_run = 0;
  int   n_fail = 0;

  mdu_issue_ctrl_if #(.CNT_W(CNT_W)) bus ();

  mdu_issue_ctrl #(.MULT_LAT(5), .DIV_LAT(10), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // MDU stand-in: busy for LAT cycles after a mult/div start.
  logic [3:0] r_mcnt;
  logic       r_force_low = 1'b0;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_mcnt <= 4'd0;
    else if (bus.mdu_start && (bus.mdu_ctrl == MDU_MULT || bus.mdu_ctrl == MDU_MULTU)) r_mcnt <= 4'd5;
    else if (bus.mdu_start && (bus.mdu_ctrl == MDU_DIV || bus.mdu_ctrl == MDU_DIVU)) r_mcnt <= 4'd10;
    else if (r_mcnt != 4'd0) r_mcnt <= r_mcnt - 4'd1;
  end
  assign bus.mdu_busy = (r_mcnt != 4'd0) && !r_force_low;

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] rs,
                       input logic [31:0] rt, input logic fl);
    bus.e_valid = v; bus.e_mdu_op = op; bus.e_rs = rs; bus.e_rt = rt; bus.flush = fl;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    r_force_low = 1'b0;
    drive(1'b0, MD_OP_NONE, 32'd0, 32'd0, 1'b0);
    next_cycle();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1'b0, MD_OP_NONE, 32'd0, 32'd0, 1'b0);
    #3;
    n_run++; if (bus.mdu_done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b exp 0", bus.mdu_done); end
    n_run++; if (bus.err_sync !== 1'b0) begin n_fail++; $display("FAIL rst_err got %b exp 0", bus.err_sync); end
    n_run++; if (bus.busy_cycles !== 32'd0) begin n_fail++; $display("FAIL rst_busy_cnt got %0d exp 0", bus.busy_cycles); end
    n_run++; if (bus.stall_cycles !== 32'd0) begin n_fail++; $display("FAIL rst_stall_cnt got %0d exp 0", bus.stall_cycles); end
    n_run++; if (bus.mdu_start !== 1'b0) begin n_fail++; $display("FAIL rst_start got %b exp 0", bus.mdu_start); end
    n_run++; if (bus.stall_e !== 1'b0) begin n_fail++; $display("FAIL rst_stall got %b exp 0", bus.stall_e); end
    n_run++; if (bus.mdu_ctrl !== 3'd0) begin n_fail++; $display("FAIL rst_ctrl got %0d exp 0", bus.mdu_ctrl); end
  endtask

  task automatic test_mult();
    do_reset();
    drive(1'b1, MD_OP_MULT, 32'd3, 32'd4, 1'b0); #1;
    n_run++; if (bus.mdu_start !== 1'b1) begin n_fail++; $display("FAIL mult_start got %b exp 1", bus.mdu_start); end
    n_run++; if (bus.mdu_ctrl !== MDU_MULT) begin n_fail++; $display("FAIL mult_ctrl got %0d exp %0d", bus.mdu_ctrl, MDU_MULT); end
    n_run++; if (bus.mdu_src_a !== 32'd3 || bus.mdu_src_b !== 32'd4) begin n_fail++; $display("FAIL mult_src got %0d,%0d exp 3,4", bus.mdu_src_a, bus.mdu_src_b); end
    n_run++; if (bus.stall_e !== 1'b0) begin n_fail++; $display("FAIL mult_stall got %b exp 0", bus.stall_e); end
    for (int k = 1; k <= 5; k++) begin
      next_cycle(); drive(1'b0, MD_OP_NONE, 32'd0, 32'd0, 1'b0); #1;
      n_run++; if (bus.mdu_done !== 1'b0) begin n_fail++; $display("FAIL mult_done_early c%0d got %b exp 0", k, bus.mdu_done); end
      n_run++; if (bus.busy_cycles !== 32'(k - 1)) begin n_fail++; $display("FAIL mult_busy_cnt c%0d got %0d exp %0d", k, bus.busy_cycles, k - 1); end
    end
    next_cycle(); #1;
    n_run++; if (bus.mdu_done !== 1'b1) begin n_fail++; $display("FAIL mult_done got %b exp 1", bus.mdu_done); end
    n_run++; if (bus.busy_cycles !== 32'd5) begin n_fail++; $display("FAIL mult_busy_total got %0d exp 5", bus.busy_cycles); end
    n_run++; if (bus.err_sync !== 1'b0) begin n_fail++; $display("FAIL mult_err got %b exp 0", bus.err_sync); end
    next_cycle(); #1;
    n_run++; if (bus.mdu_done !== 1'b0 || bus.busy_cycles !== 32'd5) begin n_fail++; $display("FAIL mult_after got done=%b busy=%0d exp 0,5", bus.mdu_done, bus.busy_cycles); end
  endtask

  task automatic test_div_mflo();
    do_reset();
    drive(1'b1, MD_OP_DIV, 32'd100, 32'd7, 1'b0); #1;
    n_run++; if (bus.mdu_start !== 1'b1 || bus.mdu_ctrl !== MDU_DIV) begin n_fail++; $display("FAIL div_start got %b/%0d exp 1/%0d", bus.mdu_start, bus.mdu_ctrl, MDU_DIV); end
    for (int k = 1; k <= 10; k++) begin
      next_cycle(); drive(1'b1, MD_OP_MFLO, 32'd0, 32'd0, 1'b0); #1;
      n_run++; if (bus.stall_e !== 1'b1 || bus.mdu_start !== 1'b0) begin n_fail++; $display("FAIL div_stall c%0d got stall=%b start=%b exp 1,0", k, bus.stall_e, bus.mdu_start); end
    end
    next_cycle(); #1;
    n_run++; if (bus.stall_e !== 1'b0 || bus.mdu_start !== 1'b0) begin n_fail++; $display("FAIL div_mflo_go got stall=%b start=%b exp 0,0", bus.stall_e, bus.mdu_start); end
    n_run++; if (bus.mdu_ctrl !== 3'd0) begin n_fail++; $display("FAIL mflo_ctrl got %0d exp 0", bus.mdu_ctrl); end
    n_run++; if (bus.stall_cycles !== 32'd10) begin n_fail++; $display("FAIL div_stall_cnt got %0d exp 10", bus.stall_cycles); end
    n_run++; if (bus.mdu_done !== 1'b1) begin n_fail++; $display("FAIL div_done got %b exp 1", bus.mdu_done); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1'b1, MD_OP_MULTU, 32'd9, 32'd9, 1'b0); #1;
    n_run++; if (bus.mdu_start !== 1'b1 || bus.mdu_ctrl !== MDU_MULTU) begin n_fail++; $display("FAIL b2b_first got %b/%0d exp 1/%0d", bus.mdu_start, bus.mdu_ctrl, MDU_MULTU); end
    next_cycle(); drive(1'b1, MD_OP_DIVU, 32'd50, 32'd5, 1'b0); #1;
    for (int k = 1; k <= 5; k++) begin
      n_run++; if (bus.stall_e !== 1'b1 || bus.mdu_start !== 1'b0) begin n_fail++; $display("FAIL b2b_hold c%0d got stall=%b start=%b exp 1,0", k, bus.stall_e, bus.mdu_start); end
      next_cycle(); #1;
    end
    n_run++; if (bus.mdu_start !== 1'b1 || bus.mdu_done !== 1'b1 || bus.stall_e !== 1'b0) begin n_fail++; $display("FAIL b2b_issue got start=%b done=%b stall=%b exp 1,1,0", bus.mdu_start, bus.mdu_done, bus.stall_e); end
    next_cycle(); drive(1'b0, MD_OP_NONE, 32'd0, 32'd0, 1'b0);
    for (int k = 0; k < 10; k++) next_cycle();
    #1;
    n_run++; if (bus.mdu_done !== 1'b1 || bus.busy_cycles !== 32'd15) begin n_fail++; $display("FAIL b2b_done got done=%b busy=%0d exp 1,15", bus.mdu_done, bus.busy_cycles); end
    n_run++; if (bus.err_sync !== 1'b0) begin n_fail++; $display("FAIL b2b_err got %b exp 0", bus.err_sync); end
  endtask

  task automatic test_mt();
    do_reset();
    drive(1'b1, MD_OP_MTLO, 32'h1234, 32'd0, 1'b0); #1;
    n_run++; if (bus.mdu_start !== 1'b1 || bus.mdu_ctrl !== MDU_MTLO || bus.mdu_src_a !== 32'h1234) begin n_fail++; $display("FAIL mtlo got start=%b ctrl=%0d a=%h exp 1,%0d,1234", bus.mdu_start, bus.mdu_ctrl, bus.mdu_src_a, MDU_MTLO); end
    next_cycle(); drive(1'b1, MD_OP_MFLO, 32'd0, 32'd0, 1'b0); #1;
    n_run++; if (bus.stall_e !== 1'b0 || bus.mdu_start !== 1'b0) begin n_fail++; $display("FAIL mt_mflo got stall=%b start=%b exp 0,0", bus.stall_e, bus.mdu_start); end
    next_cycle(); drive(1'b0, MD_OP_NONE, 32'd0, 32'd0, 1'b0); #1;
    n_run++; if (bus.busy_cycles !== 32'd0 || bus.mdu_done !== 1'b0 || bus.err_sync !== 1'b0) begin n_fail++; $display("FAIL mt_idle got busy=%0d done=%b err=%b exp 0,0,0", bus.busy_cycles, bus.mdu_done, bus.err_sync); end
  endtask

  task automatic test_flush();
    do_reset();
    drive(1'b1, MD_OP_MULTU, 32'd2, 32'd3, 1'b0);
    next_cycle(); drive(1'b1, MD_OP_DIV, 32'd8, 32'd2, 1'b0); #1;
    n_run++; if (bus.stall_e !== 1'b1) begin n_fail++; $display("FAIL flush_pre_stall got %b exp 1", bus.stall_e); end
    next_cycle(); drive(1'b1, MD_OP_DIV, 32'd8, 32'd2, 1'b1); #1;
    n_run++; if (bus.stall_e !== 1'b0 || bus.mdu_start !== 1'b0) begin n_fail++; $display("FAIL flush_kill got stall=%b start=%b exp 0,0", bus.stall_e, bus.mdu_start); end
    next_cycle(); drive(1'b0, MD_OP_NONE, 32'd0, 32'd0, 1'b0);
    next_cycle(); next_cycle(); next_cycle(); #1;
    n_run++; if (bus.mdu_done !== 1'b1 || bus.stall_cycles !== 32'd1) begin n_fail++; $display("FAIL flush_done got done=%b stalls=%0d exp 1,1", bus.mdu_done, bus.stall_cycles); end
    n_run++; if (bus.err_sync !== 1'b0) begin n_fail++; $display("FAIL flush_err got %b exp 0", bus.err_sync); end
  endtask

  task automatic test_err_sync();
    do_reset();
    drive(1'b1, MD_OP_MULT, 32'd1, 32'd1, 1'b0);
    next_cycle(); drive(1'b0, MD_OP_NONE, 32'd0, 32'd0, 1'b0);
    next_cycle(); next_cycle(); r_force_low = 1'b1; #1;
    n_run++; if (bus.err_sync !== 1'b0) begin n_fail++; $display("FAIL err_early got %b exp 0", bus.err_sync); end
    next_cycle(); r_force_low = 1'b0; #1;
    n_run++; if (bus.err_sync !== 1'b1) begin n_fail++; $display("FAIL err_set got %b exp 1", bus.err_sync); end
    next_cycle(); next_cycle(); #1;
    n_run++; if (bus.mdu_done !== 1'b1) begin n_fail++; $display("FAIL err_done got %b exp 1", bus.mdu_done); end
    next_cycle(); next_cycle(); #1;
    n_run++; if (bus.err_sync !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %b exp 1", bus.err_sync); end
    reset = 1'b0; #1;
    n_run++; if (bus.err_sync !== 1'b0) begin n_fail++; $display("FAIL err_clear got %b exp 0", bus.err_sync); end
    next_cycle(); reset = 1'b1;
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(1'b1, MD_OP_DIV, 32'd60, 32'd6, 1'b0);
    next_cycle(); drive(1'b0, MD_OP_NONE, 32'd0, 32'd0, 1'b0);
    next_cycle(); next_cycle(); next_cycle();
    next_cycle(); drive(1'b1, MD_OP_MFLO, 32'd0, 32'd0, 1'b0); #1;
    n_run++; if (bus.stall_e !== 1'b1 || bus.busy_cycles !== 32'd4) begin n_fail++; $display("FAIL ar_pre got stall=%b busy=%0d exp 1,4", bus.stall_e, bus.busy_cycles); end
    #1; reset = 1'b0; #1;
    n_run++; if (bus.stall_e !== 1'b0 || bus.busy_cycles !== 32'd0 || bus.stall_cycles !== 32'd0) begin n_fail++; $display("FAIL ar_now got stall=%b busy=%0d stalls=%0d exp 0,0,0", bus.stall_e, bus.busy_cycles, bus.stall_cycles); end
    next_cycle(); reset = 1'b1; #1;
    next_cycle(); #1;
    n_run++; if (bus.stall_e !== 1'b0 || bus.err_sync !== 1'b0 || bus.busy_cycles !== 32'd0) begin n_fail++; $display("FAIL ar_after got stall=%b err=%b busy=%0d exp 0,0,0", bus.stall_e, bus.err_sync, bus.busy_cycles); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div_mflo();
    test_back_to_back();
    test_mt();
    test_flush();
    test_err_sync();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/mdu_issue_ctrl.md
Name: mdu_issue_ctrl

Overview:
- Sequences the multi-cycle multiply/divide unit (MDU) from the E stage.
- Decides when an MDU instruction may start.
- Stalls the pipeline on busy/read hazards and suppresses starts on flush.
- Mirrors MDU occupancy with its own countdown, cross-checks it against the unit's Busy, and keeps performance counters.

Parameters:
- MULT_LAT, 5, cycles mult/multu keeps MDU busy; must equal MDU's load value.
- DIV_LAT, 10, cycles div/divu keeps MDU busy; must equal MDU's load value.
- CNT_W, 32, width of performance counters.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- e_valid  in  1  E-stage holds a real instruction.
- e_mdu_op  in  4  E-stage MDU op code (`mdOpNone/Mult/Multu/Div/Divu/Mthi/Mtlo/Mfhi/Mflo`).
- e_rs  in  32  forwarded rs value.
- e_rt  in  32  forwarded rt value.
- flush  in  1  exception/interrupt kills E-stage instruction this cycle.
- mdu_busy  in  1  Busy from MDU.
- mdu_start  out  1  Start to MDU.
- mdu_ctrl  out  3  MDUCtrl to MDU.
- mdu_src_a  out  32  SrcA to MDU.
- mdu_src_b  out  32  SrcB to MDU.
- stall_e  out  1  freeze F/D/E, bubble into M.
- mdu_done  out  1  one-cycle pulse when the tracked operation completes.
- err_sync  out  1  sticky: own tracking disagreed with mdu_busy.
- busy_cycles  out  CNT_W  cycles spent in BUSY.
- stall_cycles  out  CNT_W  cycles stall_e was asserted.

Behaviour:
- Reset values (asynchronous, while reset==0): state=IDLE, cnt=0, mdu_done=0, err_sync=0, both perf counters=0. Combinational outputs are 0 whenever inputs imply it.
- Decode:
  - is_md = mult/multu/div/divu.
  - is_mt = mthi/mtlo.
  - is_mf = mfhi/mflo.
  - any_md = is_md|is_mt|is_mf.
- stall_e = e_valid & any_md & (state==BUSY) & ~flush. Flush wins over stall.
- issue = e_valid & (is_md|is_mt) & (state==IDLE) & ~flush.
- mdu_start = issue.
- mdu_ctrl = mapped `mduMult/Multu/Div/Divu/Mthi/Mtlo` code when e_mdu_op is in the issuable set, else 0.
- mdu_src_a = e_rs, mdu_src_b = e_rt.
- mf ops never start the MDU. In IDLE they pass without stall; hi/lo are already final.
- FSM has two states: IDLE and BUSY.
  - IDLE -> BUSY on issue & is_md. cnt <= MULT_LAT (mult*) or DIV_LAT (div*).
  - is_mt issue stays IDLE: single-cycle write, no busy.
  - BUSY: cnt <= cnt-1 each cycle. When cnt==1, next state is IDLE with cnt=0, and mdu_done is registered 1 for exactly that first IDLE cycle.
- Timing: start in cycle t ->
  - BUSY for cycles t+1..t+LAT.
  - hi/lo valid and state IDLE at t+LAT+1.
  - An mf in E during t+1..t+LAT stalls and proceeds at t+LAT+1.
  - A back-to-back md op may issue at t+LAT+1.
- No issue in BUSY, so no simultaneous start/complete. Issue is allowed in the mdu_done cycle.
- Flush during BUSY: the running operation is not aborted; it completes and pulses mdu_done. Flush only drops the E instruction, so no start and no stall.
- Cross-check, evaluated every cycle:
  - In BUSY, mdu_busy must be 1.
  - In IDLE, mdu_busy must be 0.
  - Any mismatch sets err_sync (sticky until reset). Behaviour otherwise unchanged.
- Perf counters: each increments by 1 per qualifying cycle and wraps modulo 2^CNT_W.
- Reset asserted mid-operation: immediate return to IDLE and counters cleared. The MDU shares the reset domain.

Decomposition:
- Shared define file gains:
  - `mdOp*` E-stage op codes (4-bit).
  - MULT_LAT/DIV_LAT defaults, so both MDU and controller use one source.
  - The existing `mdu*` MDUCtrl codes are reused unchanged.
- One sub-module is natural: mdu_busy_tracker (IDLE/BUSY FSM, cnt, mdu_done, err_sync).
- Decode, stall and perf logic stay in the top.

Test Plan:
- mult 3*4 in E at t, no other traffic -> mdu_start=1 at t with mdu_ctrl=`mduMult`; BUSY t+1..t+5; mdu_done at t+6; err_sync=0.
- div issued, mflo in E at t+1 -> stall_e=1 for t+1..t+10 (10 cycles, stall_cycles=10); mflo proceeds at t+11; lo=quotient.
- mtlo 0x1234 in IDLE -> start=1 for one cycle; state stays IDLE; next-cycle mflo not stalled and reads 0x1234.
- multu busy, then div in E with flush=1 at t+2 -> stall_e=0, mdu_start=0; multu still finishes at t+6 with mdu_done=1.
- Force mdu_busy=0 during BUSY cycle 3 -> err_sync=1 next cycle and stays 1 until reset=0.
- reset=0 asynchronously mid-div (cnt=6) -> state IDLE, busy_cycles=0, stall_e=0 without waiting for clk.
